// File: rtl/isqrt_pkg.sv
// Shared widths and per-stage payload for the integer square-root checker pipe.
package isqrt_pkg;

  localparam int X_W   = 32;
  localparam int Y_W   = 16;
  localparam int REM_W = 17;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] acc;
  } chk_pl_t;

endpackage

// File: rtl/isqrt_check_stage.sv
// One partial-product step of y*y: adds y[OFF +: B] * y << OFF into the accumulator.
module isqrt_check_stage
  import isqrt_pkg::*;
#(
  parameter int OFF = 0,
  parameter int B   = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_vld,
  input  chk_pl_t in_pl,
  output logic    out_vld,
  output chk_pl_t out_pl
);

  logic [X_W-1:0] w_pp;
  logic           r_vld;
  chk_pl_t        r_pl;

  // The running sum is bounded by y*y, so 32 bits never overflows.
  assign w_pp = (X_W'(in_pl.y[OFF +: B]) * X_W'(in_pl.y)) << OFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld <= 1'b0;
    else     r_vld <= in_vld;
  end

  // Data path is unreset and only moves when a pair is present.
  always_ff @(posedge clk) begin
    if (in_vld) begin
      r_pl.x   <= in_pl.x;
      r_pl.y   <= in_pl.y;
      r_pl.acc <= in_pl.acc + w_pp;
    end
  end

  assign out_vld = r_vld;
  assign out_pl  = r_pl;

endmodule

// File: rtl/isqrt_check_pipe.sv
// Pipelined checker: squares a claimed root y over STAGES steps and reports whether
// y == floor(sqrt(x)), plus y*y and the remainder x - y*y.
module isqrt_check_pipe
  import isqrt_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  output logic             res_vld,
  output logic             ok,
  output logic [X_W-1:0]   sq,
  output logic [REM_W-1:0] rem
);

  localparam int B = Y_W / STAGES;

  logic [STAGES:0] vld_pipe;
  chk_pl_t         w_pl [STAGES+1];

  assign vld_pipe[0] = x_vld;
  assign w_pl[0]     = '{x: x, y: y, acc: '0};

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    isqrt_check_stage #(
      .OFF(k * B),
      .B  (B)
    ) u_stg (
      .clk    (clk),
      .rst    (rst),
      .in_vld (vld_pipe[k]),
      .in_pl  (w_pl[k]),
      .out_vld(vld_pipe[k+1]),
      .out_pl (w_pl[k+1])
    );
  end

  logic [X_W:0]   w_d;
  logic [REM_W-1:0] w_two_y;
  logic           w_ok;

  // A valid remainder is at most 2y, so anything above bit 16 already fails.
  assign w_d     = {1'b0, w_pl[STAGES].x} - {1'b0, w_pl[STAGES].acc};
  assign w_two_y = {w_pl[STAGES].y, 1'b0};
  assign w_ok    = ~w_d[X_W] & ~|w_d[X_W-1:REM_W] & (w_d[REM_W-1:0] <= w_two_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld <= 1'b0;
      ok      <= 1'b0;
      sq      <= '0;
      rem     <= '0;
    end else begin
      res_vld <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        ok  <= w_ok;
        sq  <= w_pl[STAGES].acc;
        rem <= w_ok ? w_d[REM_W-1:0] : '0;
      end
    end
  end

endmodule
